// File: rtl/rem_pkg.sv
// ============================================================================
// Module  : rem_pkg
// Brief   : Shared definitions for the remainder/divide path: FSM state
//           encodings and sign-magnitude field helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rem_pkg;

    // Recompose FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } rem_state_t;

    // Sign bit index of a w-bit sign-magnitude word (MAG slice is [w-2:0])
    function automatic int sm_sign_idx(input int w);
        return w - 1;
    endfunction

    // Width of the wide (remainder / dividend) word built from w-bit operands
    function automatic int sm_wide(input int w);
        return 2 * w - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sm_mag_step.sv
// ============================================================================
// Module  : sm_mag_step
// Brief   : One combinational shift-add multiply step on magnitudes:
//           conditionally adds the multiplicand and shifts it left.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sm_mag_step #(
    parameter int MW = 4
) (
    input  logic [MW-1:0] acc,
    input  logic [MW-1:0] mcand,
    input  logic          mult_bit,
    output logic [MW-1:0] acc_next,
    output logic [MW-1:0] mcand_next
);

    // Add the multiplicand when the current multiplier bit is set; double it
    always_comb begin
        acc_next   = mult_bit ? (acc + mcand) : acc;
        mcand_next = {mcand[MW-2:0], 1'b0};
    end

endmodule

`default_nettype wire

// File: rtl/rem_recompose.sv
// ============================================================================
// Module  : rem_recompose
// Brief   : Sequential recomposition A = Q*B + R on sign-magnitude operands,
//           with valid/ready handshakes and range/sign/zero-divisor checks.
//           Optional macro RECOMP_ERR_STICKY_EN adds err_clr / err_sticky.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rem_recompose
    import rem_pkg::*;
#(
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   b_in,
    input  logic [W-1:0]   q_in,
    input  logic [2*W-2:0] r_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-2:0] a_out,
    output logic           err_zdiv,
    output logic           err_range,
    output logic           err_sign
`ifdef RECOMP_ERR_STICKY_EN
    ,
    input  logic           err_clr,
    output logic           err_sticky
`endif
);

    localparam int SB   = sm_sign_idx(W);   // operand sign bit
    localparam int AW   = sm_wide(W);       // wide word width
    localparam int WSB  = AW - 1;           // wide word sign bit
    localparam int MW   = AW - 1;           // wide magnitude width
    localparam int QM   = W - 1;            // operand magnitude width
    localparam int CW   = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_MUL = CW'(W - 2);

    rem_state_t      state;
    logic [CW-1:0]   cnt;
    logic [MW-1:0]   acc;
    logic [MW-1:0]   mcand;
    logic [QM-1:0]   mult;
    logic [QM-1:0]   b_mag;
    logic [MW-1:0]   r_mag;
    logic            b_sign;
    logic            q_sign;
    logic            r_sign;
    logic            q_nz;

    logic [MW-1:0]   step_acc;
    logic [MW-1:0]   step_mcand;

    logic            calc_zdiv;
    logic            calc_range;
    logic            calc_sgn_err;
    logic            prod_sign;
    logic [MW-1:0]   sum_mag;
    logic [MW-1:0]   res_mag;
    logic            res_sign;

    sm_mag_step #(
        .MW (MW)
    ) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mult_bit   (mult[0]),
        .acc_next   (step_acc),
        .mcand_next (step_mcand)
    );

    // Final add, sign resolution and error flags evaluated during ADD
    always_comb begin
        calc_zdiv    = (b_mag == '0);
        sum_mag      = acc + r_mag;
        prod_sign    = q_nz ? (q_sign ^ b_sign) : r_sign;
        calc_range   = !calc_zdiv && (r_mag >= {{(MW-QM){1'b0}}, b_mag});
        calc_sgn_err = !calc_zdiv && (r_mag != '0) && (r_sign != prod_sign);
        res_mag      = calc_zdiv ? '0 : sum_mag;
        res_sign     = (res_mag != '0) && prod_sign;
    end

    // Control FSM with handshake, multiply loop and registered results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mult      <= '0;
            b_mag     <= '0;
            r_mag     <= '0;
            b_sign    <= 1'b0;
            q_sign    <= 1'b0;
            r_sign    <= 1'b0;
            q_nz      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_out     <= '0;
            err_zdiv  <= 1'b0;
            err_range <= 1'b0;
            err_sign  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        b_mag    <= b_in[QM-1:0];
                        mcand    <= {{(MW-QM){1'b0}}, b_in[QM-1:0]};
                        mult     <= q_in[QM-1:0];
                        q_nz     <= (q_in[QM-1:0] != '0);
                        r_mag    <= r_in[MW-1:0];
                        b_sign   <= b_in[SB];
                        q_sign   <= q_in[SB];
                        r_sign   <= r_in[WSB];
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc   <= step_acc;
                    mcand <= step_mcand;
                    mult  <= mult >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_MUL) begin
                        state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    a_out     <= {res_sign, res_mag};
                    err_zdiv  <= calc_zdiv;
                    err_range <= calc_range;
                    err_sign  <= calc_sgn_err;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef RECOMP_ERR_STICKY_EN
    // Sticky error: set on an erroneous result handshake, cleared by err_clr
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if ((state == ST_DONE) && out_valid && out_ready &&
                     (err_zdiv || err_range || err_sign)) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rem_recompose.sv
// ============================================================================
// Module  : tb_rem_recompose
// Brief   : Scoreboard bench for rem_recompose (W=3).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rem_recompose;

    localparam int W  = 3;
    localparam int AW = 2 * W - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  b_in;
    logic [W-1:0]  q_in;
    logic [AW-1:0] r_in;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] a_out;
    logic          err_zdiv;
    logic          err_range;
    logic          err_sign;
`ifdef RECOMP_ERR_STICKY_EN
    logic          err_clr;
    logic          err_sticky;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic          zdiv;
        logic          rng;
        logic          sgn;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rem_recompose #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .b_in      (b_in),
        .q_in      (q_in),
        .r_in      (r_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .err_zdiv  (err_zdiv),
        .err_range (err_range),
        .err_sign  (err_sign)
`ifdef RECOMP_ERR_STICKY_EN
        ,
        .err_clr   (err_clr),
        .err_sticky(err_sticky)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: A = Q*B + R on sign-magnitude values
    function automatic exp_t model(input logic [W-1:0] b, input logic [W-1:0] q, input logic [AW-1:0] r);
        exp_t          e;
        int            bm;
        int            qm;
        int            rm;
        int            mag;
        logic          sp;
        logic [31:0]   mag_v;
        e  = '0;
        bm = int'(b[W-2:0]);
        qm = int'(q[W-2:0]);
        rm = int'(r[AW-2:0]);
        if (bm == 0) begin
            e.zdiv = 1'b1;
            return e;
        end
        mag   = (qm * bm + rm) % (1 << (AW - 1));
        mag_v = mag;
        sp    = (qm != 0) ? (q[W-1] ^ b[W-1]) : r[AW-1];
        e.a   = {(mag != 0) && sp, mag_v[AW-2:0]};
        e.rng = (rm >= bm);
        e.sgn = (rm != 0) && (r[AW-1] != sp);
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e);
        check_eq({tag, "_a"},     32'(a_out),     32'(e.a));
        check_eq({tag, "_zdiv"},  32'(err_zdiv),  32'(e.zdiv));
        check_eq({tag, "_range"}, 32'(err_range), 32'(e.rng));
        check_eq({tag, "_sign"},  32'(err_sign),  32'(e.sgn));
    endtask

    // Drive one op, wait for the result, optionally stall with junk in_valid
    task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] q, input logic [AW-1:0] r,
                          input int stall, input bit junk);
        exp_t e;
        int   n;
        @(negedge clk);
        b_in     = b;
        q_in     = q;
        r_in     = r;
        in_valid = 1'b1;
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        sbq.push_back(model(b, q, r));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid || n >= 20) break;
            check_eq("busy_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            n++;
        end
        // W edges after the accept edge = W+1 cycles counting the accept cycle
        check_eq("latency", 32'(n), 32'(W));
        e = sbq[0];
        for (int i = 0; i < stall; i++) begin
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_result("stall", e);
            if (junk) begin
                in_valid = 1'b1;
                b_in     = 3'b001;
                q_in     = 3'b001;
                r_in     = 5'b00000;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("out_valid", 32'(out_valid), 32'd1);
        e = sbq.pop_front();
        check_result("result", e);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("post_hs_valid", 32'(out_valid), 32'd0);
        check_eq("post_hs_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_a"},         32'(a_out),     32'd0);
        check_eq({tag, "_zdiv"},      32'(err_zdiv),  32'd0);
        check_eq({tag, "_range"},     32'(err_range), 32'd0);
        check_eq({tag, "_sign"},      32'(err_sign),  32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        b_in      = '0;
        q_in      = '0;
        r_in      = '0;
`ifdef RECOMP_ERR_STICKY_EN
        err_clr   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        run_op(3'b010, 3'b011, 5'b00001, 0, 1'b0);   // +7
        run_op(3'b110, 3'b011, 5'b10001, 1, 1'b0);   // -7
        run_op(3'b110, 3'b011, 5'b00001, 0, 1'b0);   // sign error
        run_op(3'b000, 3'b011, 5'b00000, 0, 1'b0);   // divide by zero
        run_op(3'b010, 3'b001, 5'b00010, 0, 1'b0);   // range error
        run_op(3'b011, 3'b111, 5'b10010, 2, 1'b0);   // -11, max magnitude
        run_op(3'b010, 3'b000, 5'b00000, 0, 1'b0);   // zero result, sign 0
        run_op(3'b110, 3'b000, 5'b10001, 0, 1'b0);   // |Q|=0 takes r sign
        run_op(3'b010, 3'b011, 5'b00001, 5, 1'b1);   // stall with junk in_valid

        // Reset during MUL abandons the op
        @(negedge clk);
        b_in     = 3'b011;
        q_in     = 3'b011;
        r_in     = 5'b00001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("mid_reset");
        run_op(3'b011, 3'b011, 5'b00010, 0, 1'b0);   // +11 after abort

        for (int k = 0; k < 8; k++) begin
            run_op(W'($urandom), W'($urandom), AW'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end

        check_eq("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
